// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus bundle: redirect/throttle inputs, instruction-memory
// request/response channel and the decode-side valid/ready stream.
interface fetch_queue_stage_if;
    logic        fetch_enable;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] instruction;
    logic [15:0] PC_2;
    logic        halted;

    modport master (
        input  fetch_enable, redirect, redirect_pc, imem_valid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, instruction, PC_2, halted
    );

    modport slave (
        output fetch_enable, redirect, redirect_pc, imem_valid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, instruction, PC_2, halted
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// buffers returned instructions in an in-order FIFO feeding decode.
module fetch_queue_stage #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_queue_stage_if.master   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;

    state_t        state, state_next;
    logic [15:0]   pc, req_pc, last_pc2, req_pc_inc;
    logic [15:0]   instr_q [DEPTH];
    logic [15:0]   pc2_q   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          issue, enq, deq, is_halt, not_empty;

    assign req_pc_inc = req_pc + 16'd2;
    assign is_halt    = (bus.imem_rdata[15:11] == 5'b00000);
    assign not_empty  = (count != '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; redirect outranks everything except a response
    // that has to be consumed in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.redirect)  state_next = IDLE;
                else if (issue)    state_next = WAIT;
            end
            WAIT: begin
                if (bus.redirect)        state_next = bus.imem_valid ? IDLE : DROP;
                else if (bus.imem_valid) state_next = is_halt ? HALTED : IDLE;
            end
            DROP: begin
                if (bus.imem_valid) state_next = IDLE;
            end
            HALTED: begin
                if (bus.redirect) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        issue = rst && (state == IDLE) && bus.fetch_enable && !bus.redirect
                && (count < CW'(DEPTH));
        enq   = (state == WAIT) && bus.imem_valid && !bus.redirect;
        deq   = not_empty && bus.if_ready && !bus.redirect;

        bus.imem_req    = issue;
        bus.imem_addr   = pc;
        bus.halted      = (state == HALTED);
        bus.if_valid    = not_empty;
        bus.instruction = not_empty ? instr_q[rd_ptr] : NOP_INSTR;
        bus.PC_2        = not_empty ? pc2_q[rd_ptr]   : last_pc2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            last_pc2 <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) req_pc <= pc;

            if (bus.redirect)  pc <= bus.redirect_pc;
            else if (enq)      pc <= req_pc_inc;

            if (deq) last_pc2 <= pc2_q[rd_ptr];

            // A redirect flushes the FIFO and cancels any concurrent pop.
            if (bus.redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                unique case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc2_q[wr_ptr]   <= req_pc_inc;
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: directed fetch sequences against a
// latency-programmable memory model; decode-side pops checked by a monitor.
module tb_fetch_queue_stage;
    logic clk;
    logic rst;

    fetch_queue_stage_if bus();

    fetch_queue_stage #(
        .DEPTH(2),
        .RESET_PC(16'h0000),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = 1;
    logic [15:0] halt_addr = 16'hFFFF;
    logic [31:0] exp_q[$];
    logic [15:0] req_log[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] s;
        s = a << 4;
        return (a == halt_addr) ? 16'h0000 : (16'h4000 | s);
    endfunction

    function automatic logic [15:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 16'hDEAD;
    endfunction

    // Memory model: one response k cycles after each request
    initial begin
        logic [15:0] a;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                a = bus.imem_addr;
                req_log.push_back(a);
                repeat (k) @(posedge clk);
                #1;
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem_rd(a);
                @(posedge clk);
                #1;
                bus.imem_valid = 1'b0;
            end
        end
    end

    // Monitor: every accepted head is compared with the scoreboard front
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst && bus.if_valid && bus.if_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", bus.instruction, 16'hXXXX);
            end else begin
                e = exp_q.pop_front();
                check("pop_instruction", bus.instruction, e[31:16]);
                check("pop_pc_2", bus.PC_2, e[15:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] a);
        step();
        req_log.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = a;
        step();
        bus.redirect    = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.halted) begin ok = 1; break; end
        end
        check(name, {15'b0, ok}, 16'd1);
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        check(name, {15'b0, ok}, 16'd1);
        @(negedge clk);
        check({name, "_if_valid"}, {15'b0, bus.if_valid}, 16'd0);
        check({name, "_nop"}, bus.instruction, 16'h0800);
    endtask

    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin ok = 1; break; end
        end
        check(name, {15'b0, ok}, 16'd1);
    endtask

    initial begin
        bit ok;
        rst              = 1'b0;
        bus.fetch_enable = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.if_ready     = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_imem_req", {15'b0, bus.imem_req}, 16'd0);
        check("rst_if_valid", {15'b0, bus.if_valid}, 16'd0);
        check("rst_instruction", bus.instruction, 16'h0800);
        check("rst_pc_2", bus.PC_2, 16'h0000);
        check("rst_halted", {15'b0, bus.halted}, 16'd0);

        // k=1 stream from 0; HALT at 4 ends it
        k = 1;
        halt_addr = 16'h0004;
        exp_q.push_back({16'h4000, 16'h0002});
        exp_q.push_back({16'h4020, 16'h0004});
        exp_q.push_back({16'h0000, 16'h0006});
        step();
        rst = 1'b1;
        wait_halted("t1_halted");
        drain("t1_drain");
        repeat (5) @(negedge clk);
        check("t1_req_count", 16'(req_log.size()), 16'd3);
        check("t1_addr0", log_at(0), 16'h0000);
        check("t1_addr1", log_at(1), 16'h0002);
        check("t1_addr2", log_at(2), 16'h0004);
        check("t1_no_req_halted", {15'b0, bus.imem_req}, 16'd0);
        check("t1_pc_2_hold", bus.PC_2, 16'h0006);

        // Exit HALT via redirect; stall decode so the FIFO fills
        halt_addr = 16'h0028;
        step();
        req_log.delete();
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0020;
        @(negedge clk);
        check("t2_no_req_redirect_cycle", {15'b0, bus.imem_req}, 16'd0);
        check("t2_halted_before", {15'b0, bus.halted}, 16'd1);
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("t2_halted_cleared", {15'b0, bus.halted}, 16'd0);
        check("t2_req", {15'b0, bus.imem_req}, 16'd1);
        check("t2_addr", bus.imem_addr, 16'h0020);
        repeat (10) @(negedge clk);
        check("t2_full_req_count", 16'(req_log.size()), 16'd2);
        check("t2_full_addr1", log_at(1), 16'h0022);
        check("t2_full_no_req", {15'b0, bus.imem_req}, 16'd0);
        check("t2_full_if_valid", {15'b0, bus.if_valid}, 16'd1);
        check("t2_full_head", bus.instruction, 16'h4200);
        check("t2_full_head_pc_2", bus.PC_2, 16'h0022);
        exp_q.push_back({16'h4200, 16'h0022});
        exp_q.push_back({16'h4220, 16'h0024});
        exp_q.push_back({16'h4240, 16'h0026});
        exp_q.push_back({16'h4260, 16'h0028});
        exp_q.push_back({16'h0000, 16'h002A});
        step();
        bus.if_ready = 1'b1;
        wait_halted("t2_halted");
        drain("t2_drain");
        check("t2_req_count", 16'(req_log.size()), 16'd5);
        check("t2_addr4", log_at(4), 16'h0028);

        // Redirect while WAIT with k=3: stale response dropped
        k = 3;
        halt_addr = 16'h0102;
        redirect_to(16'h0040);
        wait_req("t3_first_req");
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        step();
        bus.redirect    = 1'b0;
        exp_q.push_back({16'h5000, 16'h0102});
        exp_q.push_back({16'h0000, 16'h0104});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t3_stale_if_valid", {15'b0, bus.if_valid}, 16'd0);
        check("t3_req_after_drop", {15'b0, bus.imem_req}, 16'd1);
        check("t3_addr_after_drop", bus.imem_addr, 16'h0100);
        wait_halted("t3_halted");
        drain("t3_drain");
        check("t3_req_count", 16'(req_log.size()), 16'd3);

        // Redirect coinciding with imem_valid, one entry buffered
        k = 2;
        halt_addr = 16'h0080;
        bus.if_ready = 1'b0;
        redirect_to(16'h0060);
        wait_req("t4_req0");
        wait_req("t4_req1");
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (bus.imem_valid) begin ok = 1; break; end
        end
        check("t4_resp_seen", {15'b0, ok}, 16'd1);
        check("t4_one_entry", {15'b0, bus.if_valid}, 16'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0080;
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("t4_flushed", {15'b0, bus.if_valid}, 16'd0);
        check("t4_idle_req", {15'b0, bus.imem_req}, 16'd1);
        check("t4_idle_addr", bus.imem_addr, 16'h0080);
        exp_q.push_back({16'h0000, 16'h0082});
        step();
        bus.if_ready = 1'b1;
        wait_halted("t4_halted");
        drain("t4_drain");

        // fetch_enable=0 with a request in flight; PC wraps past 16'hFFFE
        k = 3;
        halt_addr = 16'h0002;
        exp_q.push_back({16'hFFE0, 16'h0000});
        redirect_to(16'hFFFE);
        wait_req("t5_req");
        step();
        bus.fetch_enable = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t5_resp_consumed", 16'(exp_q.size()), 16'd0);
        check("t5_req_count_blocked", 16'(req_log.size()), 16'd1);
        check("t5_no_req", {15'b0, bus.imem_req}, 16'd0);
        check("t5_pc_2_wrap", bus.PC_2, 16'h0000);
        exp_q.push_back({16'h4000, 16'h0002});
        exp_q.push_back({16'h0000, 16'h0004});
        step();
        bus.fetch_enable = 1'b1;
        wait_halted("t5_halted");
        drain("t5_drain");
        check("t5_wrap_addr", log_at(1), 16'h0000);
        check("t5_addr2", log_at(2), 16'h0002);
        check("t5_pc_2_last", bus.PC_2, 16'h0004);

        // Reset mid-transaction: late response ignored
        halt_addr = 16'hFFFF;
        redirect_to(16'h0200);
        wait_req("t6_req");
        step();
        rst = 1'b0;
        bus.fetch_enable = 1'b0;
        @(negedge clk);
        check("t6_rst_req", {15'b0, bus.imem_req}, 16'd0);
        check("t6_rst_pc_2", bus.PC_2, 16'h0000);
        check("t6_rst_instruction", bus.instruction, 16'h0800);
        step();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_late_if_valid", {15'b0, bus.if_valid}, 16'd0);
        check("t6_late_halted", {15'b0, bus.halted}, 16'd0);
        check("t6_late_req", {15'b0, bus.imem_req}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
